// File: rtl/risc8_uart_rx.sv
// risc8 receive UART: 8N1 deserialiser with IO-bus registers at BASE..BASE+2.
// Define RISC8_UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module risc8_uart_rx #(
  parameter logic [6:0] BASE       = 7'h30,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ren,
  input  logic       wen,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  input  logic       rx_in,
  output logic       irq
);

  localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [6:0] ADDR_BAUD = BASE;
  localparam logic [6:0] ADDR_STAT = BASE + 7'd1;
  localparam logic [6:0] ADDR_DATA = BASE + 7'd2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [7:0]       baud_div, half_div;
  logic [7:0]       cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             tick, push_req, frame_err;
  logic             overrun, framing;
  logic             pop, push_ok;
  logic [CNT_W-1:0] count;
  logic             empty, full;
  logic [7:0]       head;

  assign half_div = {1'b0, baud_div[7:1]};
  assign tick     = (cnt == 8'd0);
  assign empty    = (count == '0);
  assign irq      = ~empty;
  assign pop      = ren && (addr == ADDR_DATA) && !empty;
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // The detection cycle counts as the first clock of the half bit, so the
  // start sample lands exactly half_div clocks after rxs is first seen low.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = tick ? cnt : cnt - 8'd1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push_req    = 1'b0;
    frame_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          if (half_div == 8'd0) begin
            cnt_nxt     = baud_div;
            bit_idx_nxt = 3'd0;
            state_nxt   = S_DATA;
          end else begin
            cnt_nxt   = half_div - 8'd1;
            state_nxt = S_START;
          end
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_nxt     = baud_div;
            bit_idx_nxt = 3'd0;
            state_nxt   = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_nxt   = {rxs, shreg[7:1]};
          cnt_nxt     = baud_div;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxs) begin
            push_req  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef RISC8_UART_RX_FIFO_EN
  localparam int PTR_W = CNT_W - 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
    end
  end
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign count = CNT_W'(hold_valid);
  assign full  = hold_valid;
  assign head  = hold;

  // A push in the same cycle as a pop replaces the byte being read out.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= 8'd0;
      hold_valid <= 1'b0;
    end else if (push_ok) begin
      hold       <= shreg;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Flag sets take priority over a write-one-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= 8'd11;
      overrun  <= 1'b0;
      framing  <= 1'b0;
    end else begin
      if (wen && addr == ADDR_BAUD) baud_div <= wdata;
      overrun <= (push_req && !push_ok) ||
                 (overrun && !(wen && addr == ADDR_STAT && wdata[1]));
      framing <= frame_err ||
                 (framing && !(wen && addr == ADDR_STAT && wdata[2]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'd0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ren) begin
        if (addr == ADDR_BAUD) begin
          rdata <= baud_div;
          valid <= 1'b1;
        end else if (addr == ADDR_STAT) begin
          rdata <= {4'b0000, full, framing, overrun, ~empty};
          valid <= 1'b1;
        end else if (addr == ADDR_DATA) begin
          rdata <= empty ? 8'h00 : head;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc8_uart_rx.sv
// Scoreboard bench for risc8_uart_rx: frames driven on rx_in, expected reads queued from a byte-level model.
module tb_risc8_uart_rx;

  localparam logic [6:0] A_BAUD = 7'h30;
  localparam logic [6:0] A_STAT = 7'h31;
  localparam logic [6:0] A_DATA = 7'h32;
`ifdef RISC8_UART_RX_FIFO_EN
  localparam int MODEL_DEPTH = 4;
`else
  localparam int MODEL_DEPTH = 1;
`endif

  logic       clk, reset, ren, wen, rx_in;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       valid, irq;

  logic [7:0] m_q[$];
  logic       m_ovr, m_fe;
  logic [7:0] m_baud;
  logic [7:0] exp_q[$];
  logic [6:0] tag_q[$];
  int         checks = 0;
  int         errors = 0;

  risc8_uart_rx #(.BASE(7'h30), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .valid(valid), .rx_in(rx_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] modelStatus();
    return {4'b0000, m_q.size() == MODEL_DEPTH, m_fe, m_ovr, m_q.size() != 0};
  endfunction

  // Every bus response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got rdata %02h expected no response", rdata);
      end else begin
        logic [7:0] e;
        logic [6:0] t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput($sformatf("read_%02h", t), rdata, e);
      end
    end
  end

  task automatic busRead(input logic [6:0] a);
    logic in_range;
    @(negedge clk);
    ren = 1'b1;
    addr = a;
    in_range = 1'b1;
    if (a == A_BAUD) exp_q.push_back(m_baud);
    else if (a == A_STAT) exp_q.push_back(modelStatus());
    else if (a == A_DATA) exp_q.push_back(m_q.size() != 0 ? m_q.pop_front() : 8'h00);
    else in_range = 1'b0;
    if (in_range) tag_q.push_back(a);
    @(negedge clk);
    ren = 1'b0;
    if (!in_range) checkOutput("no_resp_valid", {7'b0, valid}, 8'h00);
  endtask

  task automatic busWrite(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wen = 1'b1;
    addr = a;
    wdata = d;
    if (a == A_BAUD) m_baud = d;
    if (a == A_STAT) begin
      if (d[1]) m_ovr = 1'b0;
      if (d[2]) m_fe = 1'b0;
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Sends the first nbits of an 8N1 frame; a full frame also updates the model.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int nbits);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_in = frame[i];
      repeat (int'(m_baud) + 1) @(negedge clk);
    end
    if (nbits == 10) begin
      if (stop_bit) rx_in = 1'b1;
      repeat (int'(m_baud) + 1) @(negedge clk);
      if (!stop_bit) m_fe = 1'b1;
      else if (m_q.size() < MODEL_DEPTH) m_q.push_back(data);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("valid_in_reset", {7'b0, valid}, 8'h00);
    reset = 1'b0;
    m_q.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_baud = 8'd11;
    @(negedge clk);
    checkOutput("rdata_after_reset", rdata, 8'h00);
    checkOutput("irq_after_reset", {7'b0, irq}, 8'h00);
  endtask

  task automatic checkIrq(input string name);
    checkOutput(name, {7'b0, irq}, {7'b0, m_q.size() != 0});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n, nr, b;
    reset = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; rx_in = 1'b1;
    m_baud = 8'd11; m_ovr = 1'b0; m_fe = 1'b0;
    doReset();
    busRead(A_BAUD);
    busRead(A_STAT);
    busRead(A_DATA);
    busRead(7'h33);
    busRead(7'h2F);
    checkIrq("irq_idle");

    // Abandoned frame: reset midway, nothing may appear afterwards.
    busRead(A_BAUD);
    applyStimulus(8'h00, 1'b1, 5);
    doReset();
    repeat (150) @(negedge clk);
    busRead(A_STAT);
    checkIrq("irq_after_midframe_reset");

    busWrite(A_BAUD, 8'd3);
    busRead(A_BAUD);
    applyStimulus(8'hA5, 1'b1, 10);
    busRead(A_STAT);
    checkIrq("irq_basic");
    busRead(A_DATA);
    busRead(A_STAT);

    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    busRead(A_STAT);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 10);
    busRead(A_DATA);

    applyStimulus(8'h3C, 1'b0, 10);
    repeat (20) @(negedge clk);
    busRead(A_STAT);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    busWrite(A_STAT, 8'h04);
    busRead(A_STAT);
    applyStimulus(8'h3C, 1'b1, 10);
    busRead(A_DATA);
    checkIrq("irq_after_framing");

    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 10);
    busRead(A_STAT);
    checkIrq("irq_overrun");
    for (int i = 0; i < 5; i++) busRead(A_DATA);
    busWrite(A_STAT, 8'h02);
    busRead(A_STAT);

    // Pop lands on the STOP-sample edge of the next frame.
    applyStimulus(8'h11, 1'b1, 10);
    b = int'(m_baud);
    fork
      applyStimulus(8'h22, 1'b1, 10);
      begin
        repeat (1 + b / 2 + 9 * (b + 1)) @(negedge clk);
        busRead(A_DATA);
      end
    join
    busRead(A_DATA);
    busRead(A_STAT);

    for (int it = 0; it < 15; it++) begin
      busWrite(A_BAUD, 8'($urandom_range(1, 9)));
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) applyStimulus(8'($urandom), 1'b1, 10);
      checkIrq("irq_rand");
      busRead(A_STAT);
      nr = $urandom_range(0, 3);
      for (int k = 0; k < nr; k++) begin
        busRead(A_DATA);
        if ($urandom_range(0, 1) == 1) busRead(A_STAT);
      end
      if ($urandom_range(0, 1) == 1) busWrite(A_STAT, 8'h02);
      busRead(A_STAT);
    end

    while (m_q.size() != 0) busRead(A_DATA);
    busWrite(A_STAT, 8'h06);
    busRead(A_STAT);
    checkIrq("irq_final");
    repeat (5) @(negedge clk);
    checkOutput("pending_responses", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
